// File: rtl/layer_draw_arbiter.sv
// Per-pixel draw arbiter for one layer with a frame-synchronous show/blink/hide sequencer.
// Priority rotates only at frame starts, so the winner for a given request set is stable within a frame.
module layer_draw_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ROTATE       = 1,
  parameter int BLINK_FRAMES = 16,
  parameter int BLINK_COUNT  = 3,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [N_REQ-1:0]     drawRequest,
  input  logic [8*N_REQ-1:0]   RGB,
  input  logic                 blinkStart,
  input  logic                 restore,
  output logic                 drawRequestOut,
  output logic [7:0]           RGB_Out,
  output logic [IDX_W-1:0]     winnerIdx,
  output logic                 layerVisible,
  output logic                 layerHidden
);

  typedef enum logic [1:0] {SHOWN, BLINK_OFF, BLINK_ON, HIDDEN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [3:0]       pair_cnt_q, pair_cnt_d;
  logic             blink_pend_q, blink_pend_d;
  logic             restore_pend_q, restore_pend_d;
  logic             draw_q, draw_d;
  logic [7:0]       rgb_q, rgb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             visible_q, visible_d;
  logic             hidden_q, hidden_d;
  logic             blink_evt, restore_evt, found;
  int               cand;

  always_comb begin
    blink_evt      = blink_pend_q | blinkStart;
    restore_evt    = restore_pend_q | restore;
    state_d        = state_q;
    ptr_d          = ptr_q;
    frame_cnt_d    = frame_cnt_q;
    pair_cnt_d     = pair_cnt_q;
    blink_pend_d   = blink_evt;
    restore_pend_d = restore_evt;

    if (startOfFrame) begin
      // Pending events are consumed at every frame start, used or not.
      blink_pend_d   = 1'b0;
      restore_pend_d = 1'b0;
      if (ROTATE != 0)
        ptr_d = (ptr_q == IDX_W'(N_REQ - 1)) ? '0 : ptr_q + 1'b1;
      case (state_q)
        SHOWN: if (blink_evt) begin
          state_d     = BLINK_OFF;
          frame_cnt_d = '0;
          pair_cnt_d  = '0;
        end
        BLINK_OFF: if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
          state_d     = BLINK_ON;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        BLINK_ON: if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt_d = '0;
          pair_cnt_d  = pair_cnt_q + 4'd1;
          state_d     = (pair_cnt_q + 4'd1 == 4'(BLINK_COUNT)) ? HIDDEN : BLINK_OFF;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        HIDDEN: if (restore_evt) state_d = SHOWN;
        default: state_d = SHOWN;
      endcase
    end

    visible_d = (state_d == SHOWN) || (state_d == BLINK_ON);
    hidden_d  = (state_d == HIDDEN);

    // Arbitrate with the post-edge pointer and state so the first pixel of a frame sees them.
    found = 1'b0;
    cand  = 0;
    draw_d = 1'b0;
    rgb_d  = '0;
    idx_d  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_d) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && visible_d && drawRequest[cand]) begin
        found  = 1'b1;
        draw_d = 1'b1;
        rgb_d  = RGB[8*cand +: 8];
        idx_d  = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= SHOWN;
      ptr_q          <= '0;
      frame_cnt_q    <= '0;
      pair_cnt_q     <= '0;
      blink_pend_q   <= 1'b0;
      restore_pend_q <= 1'b0;
      draw_q         <= 1'b0;
      rgb_q          <= '0;
      idx_q          <= '0;
      visible_q      <= 1'b1;
      hidden_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      frame_cnt_q    <= frame_cnt_d;
      pair_cnt_q     <= pair_cnt_d;
      blink_pend_q   <= blink_pend_d;
      restore_pend_q <= restore_pend_d;
      draw_q         <= draw_d;
      rgb_q          <= rgb_d;
      idx_q          <= idx_d;
      visible_q      <= visible_d;
      hidden_q       <= hidden_d;
    end
  end

  assign drawRequestOut = draw_q;
  assign RGB_Out        = rgb_q;
  assign winnerIdx      = idx_q;
  assign layerVisible   = visible_q;
  assign layerHidden    = hidden_q;

endmodule

// File: tb/tb_layer_draw_arbiter.sv
// Bench for layer_draw_arbiter: a rotating and a fixed-priority instance share all inputs and are
// compared each cycle against a frame-counting reference model.
module tb_layer_draw_arbiter;
  localparam int N  = 4;
  localparam int BF = 2;
  localparam int BC = 2;

  logic           clk = 1'b0;
  logic           reset, sof, bs, rs;
  logic [N-1:0]   req;
  logic [8*N-1:0] rgb;
  logic           r_draw, r_vis, r_hid, f_draw, f_vis, f_hid;
  logic [7:0]     r_rgb, f_rgb;
  logic [1:0]     r_idx, f_idx;

  int compared   = 0;
  int mismatched = 0;

  // Model: mode 0 shown, 1 blinking, 2 hidden; m_f counts frame starts since the blink began.
  int         m_ptr, m_mode, m_f;
  logic       m_pb, m_pr;
  logic       e_vis, e_hid, e_draw_r, e_draw_f;
  logic [7:0] e_rgb_r, e_rgb_f;
  int         e_idx_r, e_idx_f;
  int         rot_seq [5] = '{1, 2, 3, 0, 1};
  int         vis_seq [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  layer_draw_arbiter #(.N_REQ(N), .ROTATE(1), .BLINK_FRAMES(BF), .BLINK_COUNT(BC)) u_rot (
    .clk(clk), .reset(reset), .startOfFrame(sof), .drawRequest(req), .RGB(rgb),
    .blinkStart(bs), .restore(rs), .drawRequestOut(r_draw), .RGB_Out(r_rgb),
    .winnerIdx(r_idx), .layerVisible(r_vis), .layerHidden(r_hid));

  layer_draw_arbiter #(.N_REQ(N), .ROTATE(0), .BLINK_FRAMES(BF), .BLINK_COUNT(BC)) u_fix (
    .clk(clk), .reset(reset), .startOfFrame(sof), .drawRequest(req), .RGB(rgb),
    .blinkStart(bs), .restore(rs), .drawRequestOut(f_draw), .RGB_Out(f_rgb),
    .winnerIdx(f_idx), .layerVisible(f_vis), .layerHidden(f_hid));

  always #5 clk = ~clk;

  function automatic int win(int p, logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_mode = 0; m_f = 0; m_pb = 0; m_pr = 0;
    e_vis = 1; e_hid = 0;
    e_draw_r = 0; e_rgb_r = 0; e_idx_r = 0;
    e_draw_f = 0; e_rgb_f = 0; e_idx_f = 0;
  endtask

  task automatic model_edge();
    logic pb, pr;
    int w;
    if (sof) begin
      pb = m_pb | bs;
      pr = m_pr | rs;
      m_ptr = (m_ptr + 1) % N;
      if (m_mode == 0) begin
        if (pb) begin m_mode = 1; m_f = 0; end
      end else if (m_mode == 1) begin
        m_f = m_f + 1;
        if (m_f == 2 * BF * BC) m_mode = 2;
      end else if (pr) begin
        m_mode = 0;
      end
      m_pb = 0; m_pr = 0;
    end else begin
      m_pb = m_pb | bs;
      m_pr = m_pr | rs;
    end
    e_vis = (m_mode == 0) || (m_mode == 1 && ((m_f / BF) % 2 == 1));
    e_hid = (m_mode == 2);
    w = win(m_ptr, req);
    e_draw_r = e_vis && (w >= 0);
    e_rgb_r  = e_draw_r ? rgb[8*w +: 8] : 8'h00;
    e_idx_r  = e_draw_r ? w : 0;
    w = win(0, req);
    e_draw_f = e_vis && (w >= 0);
    e_rgb_f  = e_draw_f ? rgb[8*w +: 8] : 8'h00;
    e_idx_f  = e_draw_f ? w : 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rot_draw", 32'(r_draw), 32'(e_draw_r));
    check("rot_rgb",  32'(r_rgb),  32'(e_rgb_r));
    check("rot_idx",  32'(r_idx),  e_idx_r);
    check("rot_vis",  32'(r_vis),  32'(e_vis));
    check("rot_hid",  32'(r_hid),  32'(e_hid));
    check("fix_draw", 32'(f_draw), 32'(e_draw_f));
    check("fix_rgb",  32'(f_rgb),  32'(e_rgb_f));
    check("fix_idx",  32'(f_idx),  e_idx_f);
    check("fix_vis",  32'(f_vis),  32'(e_vis));
    check("fix_hid",  32'(f_hid),  32'(e_hid));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
    sof = 0; bs = 0; rs = 0;
  endtask

  initial begin
    reset = 1; sof = 0; bs = 0; rs = 0; req = '0; rgb = '0;
    m_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    reset = 0;

    // Fixed priority: request 1010 picks object 1 when the pointer is 0.
    req = 4'b1010; rgb = {8'hE0, 8'h5A, 8'h1C, 8'h33};
    tick();
    check("fix_prio_draw", 32'(f_draw), 32'd1);
    check("fix_prio_rgb",  32'(f_rgb),  32'h1C);
    check("fix_prio_idx",  32'(f_idx),  32'd1);
    req = 4'b0000;
    tick();
    check("noreq_draw", 32'(f_draw), 32'd0);
    check("noreq_rgb",  32'(f_rgb),  32'd0);
    check("noreq_idx",  32'(f_idx),  32'd0);

    // Rotation over five frame starts with all requests held.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      sof = 1;
      tick();
      check("rot_after_sof", 32'(r_idx), rot_seq[i]);
      tick(); tick();
      check("rot_hold", 32'(r_idx), rot_seq[i]);
      check("fix_hold", 32'(f_idx), 32'd0);
    end

    // Blink sequence with a discarded restore (BLINK_ON) and blinkStart (BLINK_OFF).
    req = 4'b0001;
    tick();
    bs = 1;
    tick(); tick();
    for (int fr = 0; fr < 8; fr++) begin
      sof = 1;
      tick();
      check("blink_vis", 32'(r_vis), vis_seq[fr]);
      tick();
      if (fr == 2) rs = 1;
      if (fr == 4) bs = 1;
      tick(); tick();
    end
    sof = 1;
    tick();
    check("hidden_hid",  32'(r_hid),  32'd1);
    check("hidden_draw", 32'(r_draw), 32'd0);
    tick();
    sof = 1;
    tick();
    check("hidden_stays", 32'(r_hid), 32'd1);

    // Restore coincident with the frame start.
    sof = 1; rs = 1;
    tick();
    check("restore_vis",  32'(r_vis),  32'd1);
    check("restore_hid",  32'(r_hid),  32'd0);
    check("restore_draw", 32'(r_draw), 32'd1);
    tick();
    check("restore_draw2", 32'(r_draw), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      rgb = {$urandom};
      sof = ($urandom_range(0, 5) == 0);
      bs  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 14) == 0);
      tick();
    end

    // Return to SHOWN, then start a blink that lands in BLINK_OFF with ptr 2.
    for (int i = 0; i < 40; i++) begin
      if (m_mode == 0) break;
      sof = 1; rs = 1;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (m_ptr == 1) break;
      sof = 1;
      tick();
    end
    bs = 1; sof = 1;
    tick();
    check("pre_reset_vis", 32'(r_vis), 32'd0);
    req = 4'b1111;
    tick();
    check("pre_reset_idx", 32'(r_idx), 32'd0);
    check("pre_reset_vis2", 32'(r_vis), 32'd0);

    // Asynchronous reset mid-cycle, observed before any clock edge.
    #2 reset = 1;
    #1;
    m_reset();
    check("async_draw", 32'(r_draw), 32'd0);
    check("async_rgb",  32'(r_rgb),  32'd0);
    check("async_idx",  32'(r_idx),  32'd0);
    check("async_vis",  32'(r_vis),  32'd1);
    check("async_hid",  32'(r_hid),  32'd0);
    check_all();
    @(negedge clk);
    reset = 0;
    tick();
    check("post_reset_idx",  32'(r_idx),  32'd0);
    check("post_reset_draw", 32'(r_draw), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/layer_draw_arbiter.md
# layer_draw_arbiter

Per-pixel arbiter and visibility sequencer for one drawing layer (ground, ropes, platforms). It selects one of N_REQ object draw requests each clock using a priority order that rotates only at frame boundaries. It runs a frame-synchronous show/blink/hide state machine that gates the whole layer. It sits between the object drawers and the top-level layer mux, whose input it drives with a registered draw request and colour.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- ROTATE, 1: 1 = priority pointer advances on every frame start; 0 = fixed priority, index 0 highest.
- BLINK_FRAMES, 16: frames per blink half-period, 1..255.
- BLINK_COUNT, 3: number of off/on pairs before the layer is hidden, 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- drawRequest  in  N_REQ  per-object draw request for the current pixel.
- RGB  in  8*N_REQ  object colours; object i occupies bits [8i+7:8i].
- blinkStart  in  1  pulse: blink the layer out and then hide it.
- restore  in  1  pulse: make a hidden layer visible again.
- drawRequestOut  out  1  registered layer draw request.
- RGB_Out  out  8  registered colour of the winning object.
- winnerIdx  out  $clog2(N_REQ)  registered index of the winner; 0 when there is no winner.
- layerVisible  out  1  1 in SHOWN or BLINK_ON.
- layerHidden  out  1  1 in HIDDEN.

## Operation
- **Arbitration:** the candidate order is ptr, ptr+1, …, ptr+N_REQ-1, taken modulo N_REQ. The first asserted drawRequest in that order wins.
- **Layer disabled or no request:** drawRequestOut=0, RGB_Out=0, winnerIdx=0.
- **Priority pointer ptr:**
  - Reset value is 0.
  - When ROTATE=1, ptr becomes (ptr+1) mod N_REQ on each startOfFrame. It wraps from N_REQ-1 to 0.
  - When ROTATE=0, ptr stays at 0.
  - ptr never changes mid-frame, so winners are stable within a frame.
- **Pending events:**
  - blinkStart and restore are each latched into a pending flag and acted on at the next startOfFrame, including a pulse that arrives in the same cycle as startOfFrame.
  - At each startOfFrame the flags are consumed and cleared, whether or not they caused a transition.
- **FSM states:** SHOWN (reset state), BLINK_OFF, BLINK_ON, HIDDEN. Transitions are evaluated only on startOfFrame.
  - SHOWN → BLINK_OFF when blinkStart is pending. frameCnt=0, pairCnt=0.
  - BLINK_OFF: frameCnt increments each frame. At frameCnt==BLINK_FRAMES-1, go to BLINK_ON and set frameCnt=0.
  - BLINK_ON: at frameCnt==BLINK_FRAMES-1, set pairCnt+1 and frameCnt=0. If the new pairCnt==BLINK_COUNT, go to HIDDEN; otherwise go to BLINK_OFF.
  - HIDDEN → SHOWN when restore is pending.
  - A pending restore outside HIDDEN is discarded.
  - A pending blinkStart outside SHOWN is discarded. A blink sequence is not restarted.
- **Layer enable:** state ∈ {SHOWN, BLINK_ON}.
- **Counter widths:** frameCnt is 8 bits. pairCnt is 4 bits. Neither ever exceeds its terminal value.

## Timing
- Arbiter latency is 1 clock. Outputs at edge k+1 reflect drawRequest, RGB, ptr and state sampled at edge k.
- A state change at the startOfFrame edge affects the outputs from the next edge onward. The first pixel of the frame uses the new state and the new ptr.
- Reset values, applied asynchronously:
  - drawRequestOut=0, RGB_Out=0, winnerIdx=0.
  - layerVisible=1, layerHidden=0.
  - ptr=0, state=SHOWN, all counters 0, pending flags 0.
- Reset asserted mid-blink aborts the sequence; the block returns to SHOWN on release.
- Blink timing: from the blinkStart frame edge to HIDDEN takes exactly 2·BLINK_FRAMES·BLINK_COUNT frame starts.

## Test plan
- **Fixed priority.** Settings: ROTATE=0, N_REQ=4. Stimulus: drawRequest=4'b1010, RGB1=0x1C, RGB3=0xE0. Required one clock later: drawRequestOut=1, RGB_Out=0x1C, winnerIdx=1. With drawRequest=0, all three outputs are 0.
- **Rotation.** Setting: ROTATE=1. Stimulus: drawRequest=4'b1111 held, startOfFrame pulsed 5 times. Required winnerIdx after each pulse: 1, 2, 3, 0, 1. winnerIdx is unchanged between pulses.
- **Blink.** Settings: BLINK_FRAMES=2, BLINK_COUNT=2. Stimulus: blinkStart mid-frame, drawRequest=4'b0001. Required layerVisible per frame from the next startOfFrame: 0,0,1,1,0,0,1,1. After that, layerHidden=1 and drawRequestOut=0.
- **Restore.** Stimulus: restore pulsed in HIDDEN, coincident with startOfFrame. Required: SHOWN, with drawRequestOut following drawRequest from the next clock.
- **Discard.** Stimulus: restore pulsed during BLINK_ON, then blinkStart pulsed during BLINK_OFF. Required: the sequence completes unchanged into HIDDEN, and no pending event remains in HIDDEN.
- **Reset mid-operation.** Stimulus: reset asserted in BLINK_OFF with ptr=2. Required, immediately and without a clock edge: all outputs at their reset values, layerVisible=1. Required after release: winnerIdx=0 with drawRequest=4'b1111.
